// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the pipelined MIPS control unit: opcode/funct codes,
// the per-stage control bundles, bubble constants, forwarding-select and
// mem_to_reg encodings, and the forwarding-priority helper.
package pipe_ctrl_pkg;

    localparam int DST_AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_MEM  = 2'b01;
    localparam logic [1:0] M2R_LINK = 2'b10;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam logic [DST_AW-1:0] LINK_REG = '1;

    typedef struct packed {
        logic              branch;
        logic              aluSrc;
        logic              extOp;
        logic [3:0]        aluOp;
        logic              memRead;
        logic              memWrite;
        logic [1:0]        memToReg;
        logic              regWrite;
        logic [DST_AW-1:0] dst;
    } ctrlEx_t;

    typedef struct packed {
        logic              memRead;
        logic              memWrite;
        logic [1:0]        memToReg;
        logic              regWrite;
        logic [DST_AW-1:0] dst;
    } ctrlMem_t;

    typedef struct packed {
        logic [1:0]        memToReg;
        logic              regWrite;
        logic [DST_AW-1:0] dst;
    } ctrlWb_t;

    localparam ctrlEx_t  EX_BUBBLE  = '0;
    localparam ctrlMem_t MEM_BUBBLE = '0;
    localparam ctrlWb_t  WB_BUBBLE  = '0;

    // EX/MEM has priority because it holds the younger result.
    function automatic logic [1:0] fwdSel(
        input logic              memEff,
        input logic [DST_AW-1:0] memDst,
        input logic              wbEff,
        input logic [DST_AW-1:0] wbDst,
        input logic [DST_AW-1:0] src
    );
        if (memEff && (memDst == src)) return FWD_EXMEM;
        if (wbEff && (wbDst == src))   return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode
// Combinational ID-stage decoder: opcode/funct to the ID/EX control bundle,
// plus which source registers the instruction reads and whether it jumps.
// Ports:
//   opcode, funct   : instruction [31:26] and [5:0]
//   rt, rd          : register fields used to pick the destination
//   ctrl            : decoded ID/EX control bundle
//   usesRs, usesRt  : instruction reads rs / rt
//   jump            : j, jal, jr or jalr
module ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [DST_AW-1:0] rt,
    input  logic [DST_AW-1:0] rd,
    output ctrlEx_t           ctrl,
    output logic              usesRs,
    output logic              usesRt,
    output logic              jump
);

    always_comb begin
        // R-type defaults; unknown opcodes fall through with these.
        ctrl            = EX_BUBBLE;
        ctrl.extOp      = 1'b1;
        ctrl.aluOp[2:0] = 3'b010;
        ctrl.regWrite   = 1'b1;
        ctrl.dst        = rd;
        usesRs          = 1'b1;
        usesRt          = 1'b1;
        jump            = 1'b0;

        unique case (opcode)
            OP_RTYPE: begin
                if (funct == FN_JR) begin
                    ctrl.regWrite = 1'b0;
                    usesRt        = 1'b0;
                    jump          = 1'b1;
                end else if (funct == FN_JALR) begin
                    ctrl.memToReg = M2R_LINK;
                    usesRt        = 1'b0;
                    jump          = 1'b1;
                end
            end
            OP_J: begin
                ctrl.aluOp[2:0] = 3'b000;
                ctrl.regWrite   = 1'b0;
                usesRs          = 1'b0;
                usesRt          = 1'b0;
                jump            = 1'b1;
            end
            OP_JAL: begin
                ctrl.aluOp[2:0] = 3'b000;
                ctrl.memToReg   = M2R_LINK;
                ctrl.dst        = LINK_REG;
                usesRs          = 1'b0;
                usesRt          = 1'b0;
                jump            = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.branch     = 1'b1;
                ctrl.aluOp[2:0] = (opcode == OP_BEQ) ? 3'b001 : 3'b000;
                ctrl.regWrite   = 1'b0;
            end
            OP_BLEZ, OP_BGTZ: begin
                ctrl.branch     = 1'b1;
                ctrl.aluOp[2:0] = 3'b000;
                ctrl.regWrite   = 1'b0;
                usesRt          = 1'b0;
            end
            OP_ADDI, OP_ADDIU, OP_LUI: begin
                ctrl.aluOp[2:0] = 3'b000;
                ctrl.aluSrc     = 1'b1;
                ctrl.dst        = rt;
                usesRs          = (opcode != OP_LUI);
                usesRt          = 1'b0;
            end
            OP_SLTI, OP_SLTIU: begin
                ctrl.aluOp[2:0] = 3'b101;
                ctrl.aluSrc     = 1'b1;
                ctrl.dst        = rt;
                usesRt          = 1'b0;
            end
            OP_ANDI: begin
                ctrl.aluOp[2:0] = 3'b100;
                ctrl.aluSrc     = 1'b1;
                ctrl.extOp      = 1'b0;
                ctrl.dst        = rt;
                usesRt          = 1'b0;
            end
            OP_ORI: begin
                // ori keeps rd as destination and register operand B.
                ctrl.aluOp[2:0] = 3'b011;
                usesRt          = 1'b0;
            end
            OP_LW: begin
                ctrl.aluOp[2:0] = 3'b000;
                ctrl.aluSrc     = 1'b1;
                ctrl.memRead    = 1'b1;
                ctrl.memToReg   = M2R_MEM;
                ctrl.dst        = rt;
                usesRt          = 1'b0;
            end
            OP_SW: begin
                ctrl.aluOp[2:0] = 3'b000;
                ctrl.aluSrc     = 1'b1;
                ctrl.memWrite   = 1'b1;
                ctrl.regWrite   = 1'b0;
            end
            default: ;
        endcase

        ctrl.aluOp[3] = opcode[0];
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit
// Pipelined control for the 5-stage MIPS core: decodes in ID, carries the
// control bundle through ID/EX, EX/MEM and MEM/WB, detects load-use / RAW
// hazards, generates stall, IF/ID flush and forwarding selects, and counts
// stall and flush cycles.
// Ports:
//   clk, reset                  : core clock, async active-high reset
//   opcode_id..rd_id            : IF/ID instruction fields
//   branch_taken_ex             : branch in EX resolved taken
//   stall_o, flush_if_id        : hold PC+IF/ID / load NOP into IF/ID
//   jump_id                     : jump decoded in ID
//   ex_ctrl, mem_ctrl, wb_ctrl  : ID/EX, EX/MEM, MEM/WB control registers
//   fwd_a_sel, fwd_b_sel        : EX operand source selects
//   stall_cnt, flush_cnt        : saturating event counters
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW     = DST_AW,
    parameter bit ENABLE_FWD = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        opcode_id,
    input  logic [5:0]        funct_id,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
    input  logic [REG_AW-1:0] rd_id,
    input  logic              branch_taken_ex,
    output logic              stall_o,
    output logic              flush_if_id,
    output logic              jump_id,
    output ctrlEx_t           ex_ctrl,
    output ctrlMem_t          mem_ctrl,
    output ctrlWb_t           wb_ctrl,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    ctrlEx_t           decCtrl;
    logic              usesRs;
    logic              usesRt;
    logic              decJump;
    logic [REG_AW-1:0] exRs;
    logic [REG_AW-1:0] exRt;
    logic              exEff;
    logic              memEff;
    logic              wbEff;
    logic              hitEx;
    logic              hitMem;
    logic              hazard;
    logic              insertBubble;

    ctrl_decode uDecode (
        .opcode (opcode_id),
        .funct  (funct_id),
        .rt     (rt_id),
        .rd     (rd_id),
        .ctrl   (decCtrl),
        .usesRs (usesRs),
        .usesRt (usesRt),
        .jump   (decJump)
    );

    assign jump_id = decJump;

    always_comb begin
        exEff  = ex_ctrl.regWrite  && (ex_ctrl.dst  != '0);
        memEff = mem_ctrl.regWrite && (mem_ctrl.dst != '0);
        wbEff  = wb_ctrl.regWrite  && (wb_ctrl.dst  != '0);

        hitEx  = exEff  && ((usesRs && (rs_id == ex_ctrl.dst))  ||
                            (usesRt && (rt_id == ex_ctrl.dst)));
        hitMem = memEff && ((usesRs && (rs_id == mem_ctrl.dst)) ||
                            (usesRt && (rt_id == mem_ctrl.dst)));

        // Without forwarding, WB needs no stall: the register file writes
        // in the first half-cycle and ID reads in the second.
        if (ENABLE_FWD) hazard = ex_ctrl.memRead && hitEx;
        else            hazard = hitEx || hitMem;

        // A taken branch squashes the ID instruction, so any stall it
        // would have needed is moot.
        stall_o      = hazard && !branch_taken_ex && !reset;
        flush_if_id  = (branch_taken_ex || (decJump && !hazard)) && !reset;
        insertBubble = branch_taken_ex || hazard;

        if (ENABLE_FWD) begin
            fwd_a_sel = fwdSel(memEff, mem_ctrl.dst, wbEff, wb_ctrl.dst, exRs);
            fwd_b_sel = fwdSel(memEff, mem_ctrl.dst, wbEff, wb_ctrl.dst, exRt);
        end else begin
            fwd_a_sel = FWD_RF;
            fwd_b_sel = FWD_RF;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_ctrl   <= EX_BUBBLE;
            mem_ctrl  <= MEM_BUBBLE;
            wb_ctrl   <= WB_BUBBLE;
            exRs      <= '0;
            exRt      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (insertBubble) begin
                ex_ctrl <= EX_BUBBLE;
                exRs    <= '0;
                exRt    <= '0;
            end else begin
                ex_ctrl <= decCtrl;
                exRs    <= rs_id;
                exRt    <= rt_id;
            end

            mem_ctrl.memRead  <= ex_ctrl.memRead;
            mem_ctrl.memWrite <= ex_ctrl.memWrite;
            mem_ctrl.memToReg <= ex_ctrl.memToReg;
            mem_ctrl.regWrite <= ex_ctrl.regWrite;
            mem_ctrl.dst      <= ex_ctrl.dst;

            wb_ctrl.memToReg  <= mem_ctrl.memToReg;
            wb_ctrl.regWrite  <= mem_ctrl.regWrite;
            wb_ctrl.dst       <= mem_ctrl.dst;

            if (stall_o && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_if_id && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
module tb_pipe_ctrl_unit;
    import pipe_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd;
    logic       brTaken;

    logic       stallF, flushF, jumpF, stallN, flushN, jumpN;
    ctrlEx_t    exF, exN;
    ctrlMem_t   memF, memN;
    ctrlWb_t    wbF, wbN;
    logic [1:0] fwdAF, fwdBF, fwdAN, fwdBN;
    logic [15:0] stallCntF, flushCntF;
    logic [1:0]  stallCntN, flushCntN;

    int nVec = 0;
    int nErr = 0;
    ctrlEx_t expQ[$];
    ctrlEx_t expEx;

    // field order: branch aluSrc extOp aluOp memRead memWrite memToReg regWrite dst
    localparam ctrlEx_t EX_LW8    = '{1'b0, 1'b1, 1'b1, 4'b1000, 1'b1, 1'b0, 2'b01, 1'b1, 5'd8};
    localparam ctrlEx_t EX_ADD8   = '{1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 2'b00, 1'b1, 5'd8};
    localparam ctrlEx_t EX_ADD9   = '{1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 2'b00, 1'b1, 5'd9};
    localparam ctrlEx_t EX_SUB10  = '{1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 2'b00, 1'b1, 5'd10};
    localparam ctrlEx_t EX_ADDI0  = '{1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b1, 5'd0};
    localparam ctrlEx_t EX_JAL    = '{1'b0, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 2'b10, 1'b1, 5'd31};
    localparam ctrlEx_t EX_JR     = '{1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0};
    localparam ctrlEx_t EX_ANDI5  = '{1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, 2'b00, 1'b1, 5'd5};
    localparam ctrlEx_t EX_SW     = '{1'b0, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b1, 2'b00, 1'b0, 5'd7};
    localparam ctrlEx_t EX_BEQ    = '{1'b1, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 2'b00, 1'b0, 5'd3};
    localparam ctrlEx_t EX_NONE   = '0;
    localparam ctrlMem_t MEM_JAL  = '{1'b0, 1'b0, 2'b10, 1'b1, 5'd31};
    localparam ctrlMem_t MEM_SW   = '{1'b0, 1'b1, 2'b00, 1'b0, 5'd7};
    localparam ctrlWb_t  WB_JAL   = '{2'b10, 1'b1, 5'd31};
    localparam ctrlWb_t  WB_ANDI5 = '{2'b00, 1'b1, 5'd5};

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.REG_AW(5), .ENABLE_FWD(1'b1), .CNT_W(16)) dutF (
        .clk(clk), .reset(reset), .opcode_id(opcode), .funct_id(funct),
        .rs_id(rs), .rt_id(rt), .rd_id(rd), .branch_taken_ex(brTaken),
        .stall_o(stallF), .flush_if_id(flushF), .jump_id(jumpF),
        .ex_ctrl(exF), .mem_ctrl(memF), .wb_ctrl(wbF),
        .fwd_a_sel(fwdAF), .fwd_b_sel(fwdBF),
        .stall_cnt(stallCntF), .flush_cnt(flushCntF)
    );

    pipe_ctrl_unit #(.REG_AW(5), .ENABLE_FWD(1'b0), .CNT_W(2)) dutN (
        .clk(clk), .reset(reset), .opcode_id(opcode), .funct_id(funct),
        .rs_id(rs), .rt_id(rt), .rd_id(rd), .branch_taken_ex(brTaken),
        .stall_o(stallN), .flush_if_id(flushN), .jump_id(jumpN),
        .ex_ctrl(exN), .mem_ctrl(memN), .wb_ctrl(wbN),
        .fwd_a_sel(fwdAN), .fwd_b_sel(fwdBN),
        .stall_cnt(stallCntN), .flush_cnt(flushCntN)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] s,
                         input logic [4:0] t, input logic [4:0] d, input logic br);
        opcode = op; funct = fn; rs = s; rt = t; rd = d; brTaken = br;
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        drive(6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        expQ.delete();
    endtask

    task automatic test_reset();
        doReset();
        drive(OP_LW, 6'h00, 5'd1, 5'd8, 5'd0, 1'b0);
        tick();
        drive(OP_RTYPE, 6'h20, 5'd8, 5'd2, 5'd9, 1'b0);
        nVec++; if (stallF !== 1'b1) begin nErr++; $display("FAIL rst_pre_stall: got %b want 1", stallF); end
        tick();
        nVec++; if (stallCntF !== 16'd1) begin nErr++; $display("FAIL rst_pre_cnt: got %0d want 1", stallCntF); end
        drive(OP_LW, 6'h00, 5'd1, 5'd8, 5'd0, 1'b0);
        tick();
        drive(OP_RTYPE, 6'h20, 5'd8, 5'd2, 5'd9, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        nVec++; if (stallF !== 1'b0) begin nErr++; $display("FAIL rst_stall: got %b want 0", stallF); end
        nVec++; if ({exF, memF, wbF} !== '0) begin nErr++; $display("FAIL rst_bundles: got %h/%h/%h want 0", exF, memF, wbF); end
        nVec++; if ({fwdAF, fwdBF} !== 4'b0) begin nErr++; $display("FAIL rst_fwd: got %b want 0000", {fwdAF, fwdBF}); end
        nVec++; if ({stallCntF, flushCntF} !== 32'd0) begin nErr++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", stallCntF, flushCntF); end
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_load_use();
        doReset();
        drive(OP_LW, 6'h00, 5'd1, 5'd8, 5'd0, 1'b0);
        expQ.push_back(EX_LW8);
        tick();
        expEx = expQ.pop_front();
        nVec++; if (exF !== expEx) begin nErr++; $display("FAIL lu_ex_lw: got %h want %h", exF, expEx); end
        drive(OP_RTYPE, 6'h20, 5'd8, 5'd2, 5'd9, 1'b0);
        nVec++; if ({stallF, flushF} !== 2'b10) begin nErr++; $display("FAIL lu_stall: got %b want 10", {stallF, flushF}); end
        expQ.push_back(EX_NONE);
        tick();
        expEx = expQ.pop_front();
        nVec++; if (exF !== expEx) begin nErr++; $display("FAIL lu_bubble: got %h want %h", exF, expEx); end
        nVec++; if (stallF !== 1'b0) begin nErr++; $display("FAIL lu_release: got %b want 0", stallF); end
        expQ.push_back(EX_ADD9);
        tick();
        expEx = expQ.pop_front();
        nVec++; if (exF !== expEx) begin nErr++; $display("FAIL lu_ex_add: got %h want %h", exF, expEx); end
        nVec++; if ({fwdAF, fwdBF} !== 4'b0100) begin nErr++; $display("FAIL lu_fwd: got %b want 0100", {fwdAF, fwdBF}); end
        nVec++; if (stallCntF !== 16'd1) begin nErr++; $display("FAIL lu_cnt: got %0d want 1", stallCntF); end
    endtask

    task automatic test_fwd_alu();
        doReset();
        drive(OP_RTYPE, 6'h20, 5'd1, 5'd2, 5'd8, 1'b0);
        expQ.push_back(EX_ADD8);
        tick();
        expEx = expQ.pop_front();
        nVec++; if (exF !== expEx) begin nErr++; $display("FAIL fa_ex_add: got %h want %h", exF, expEx); end
        drive(OP_RTYPE, 6'h22, 5'd8, 5'd8, 5'd10, 1'b0);
        nVec++; if (stallF !== 1'b0) begin nErr++; $display("FAIL fa_stall: got %b want 0", stallF); end
        expQ.push_back(EX_SUB10);
        tick();
        expEx = expQ.pop_front();
        nVec++; if (exF !== expEx) begin nErr++; $display("FAIL fa_ex_sub: got %h want %h", exF, expEx); end
        nVec++; if ({fwdAF, fwdBF} !== 4'b1010) begin nErr++; $display("FAIL fa_fwd: got %b want 1010", {fwdAF, fwdBF}); end
        drive(OP_RTYPE, 6'h20, 5'd10, 5'd8, 5'd11, 1'b0);
        tick();
        // EX/MEM holds sub->$10, MEM/WB holds add->$8
        nVec++; if ({fwdAF, fwdBF} !== 4'b1001) begin nErr++; $display("FAIL fa_fwd_mix: got %b want 1001", {fwdAF, fwdBF}); end
    endtask

    task automatic test_nofwd();
        doReset();
        drive(OP_RTYPE, 6'h20, 5'd1, 5'd2, 5'd8, 1'b0);
        expQ.push_back(EX_ADD8);
        tick();
        expEx = expQ.pop_front();
        nVec++; if (exN !== expEx) begin nErr++; $display("FAIL nf_ex_add: got %h want %h", exN, expEx); end
        drive(OP_RTYPE, 6'h22, 5'd8, 5'd8, 5'd10, 1'b0);
        nVec++; if (stallN !== 1'b1) begin nErr++; $display("FAIL nf_stall_ex: got %b want 1", stallN); end
        expQ.push_back(EX_NONE);
        tick();
        expEx = expQ.pop_front();
        nVec++; if (exN !== expEx) begin nErr++; $display("FAIL nf_bubble1: got %h want %h", exN, expEx); end
        nVec++; if (stallN !== 1'b1) begin nErr++; $display("FAIL nf_stall_mem: got %b want 1", stallN); end
        expQ.push_back(EX_NONE);
        tick();
        expEx = expQ.pop_front();
        nVec++; if (exN !== expEx) begin nErr++; $display("FAIL nf_bubble2: got %h want %h", exN, expEx); end
        nVec++; if (stallN !== 1'b0) begin nErr++; $display("FAIL nf_wb_nohaz: got %b want 0", stallN); end
        expQ.push_back(EX_SUB10);
        tick();
        expEx = expQ.pop_front();
        nVec++; if (exN !== expEx) begin nErr++; $display("FAIL nf_ex_sub: got %h want %h", exN, expEx); end
        nVec++; if ({fwdAN, fwdBN} !== 4'b0) begin nErr++; $display("FAIL nf_fwd: got %b want 0000", {fwdAN, fwdBN}); end
        nVec++; if (stallCntN !== 2'd2) begin nErr++; $display("FAIL nf_cnt: got %0d want 2", stallCntN); end
        // two more stalls on a 2-bit counter: reaches 3 and holds there
        drive(OP_RTYPE, 6'h20, 5'd1, 5'd2, 5'd8, 1'b0);
        tick();
        drive(OP_RTYPE, 6'h22, 5'd8, 5'd8, 5'd10, 1'b0);
        tick();
        nVec++; if (stallCntN !== 2'd3) begin nErr++; $display("FAIL nf_cnt_full: got %0d want 3", stallCntN); end
        nVec++; if (stallN !== 1'b1) begin nErr++; $display("FAIL nf_stall_again: got %b want 1", stallN); end
        tick();
        nVec++; if (stallCntN !== 2'd3) begin nErr++; $display("FAIL nf_cnt_sat: got %0d want 3", stallCntN); end
    endtask

    task automatic test_zero_reg();
        doReset();
        drive(OP_ADDI, 6'h05, 5'd0, 5'd0, 5'd0, 1'b0);
        expQ.push_back(EX_ADDI0);
        tick();
        expEx = expQ.pop_front();
        nVec++; if (exF !== expEx) begin nErr++; $display("FAIL z_ex_addi: got %h want %h", exF, expEx); end
        drive(OP_RTYPE, 6'h20, 5'd0, 5'd0, 5'd3, 1'b0);
        nVec++; if ({stallF, stallN} !== 2'b00) begin nErr++; $display("FAIL z_stall: got %b want 00", {stallF, stallN}); end
        tick();
        nVec++; if ({fwdAF, fwdBF} !== 4'b0) begin nErr++; $display("FAIL z_fwd: got %b want 0000", {fwdAF, fwdBF}); end
    endtask

    task automatic test_branch_flush();
        doReset();
        drive(OP_LW, 6'h00, 5'd1, 5'd8, 5'd0, 1'b0);
        tick();
        drive(OP_RTYPE, 6'h20, 5'd8, 5'd2, 5'd9, 1'b1);
        nVec++; if ({stallF, flushF} !== 2'b01) begin nErr++; $display("FAIL bf_flags: got %b want 01", {stallF, flushF}); end
        expQ.push_back(EX_NONE);
        tick();
        expEx = expQ.pop_front();
        nVec++; if (exF !== expEx) begin nErr++; $display("FAIL bf_bubble: got %h want %h", exF, expEx); end
        nVec++; if ({flushCntF, stallCntF} !== {16'd1, 16'd0}) begin nErr++; $display("FAIL bf_cnt: got %0d/%0d want 1/0", flushCntF, stallCntF); end
        drive(6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic test_jal();
        doReset();
        drive(OP_JAL, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        nVec++; if ({jumpF, flushF, stallF} !== 3'b110) begin nErr++; $display("FAIL jal_flags: got %b want 110", {jumpF, flushF, stallF}); end
        expQ.push_back(EX_JAL);
        tick();
        expEx = expQ.pop_front();
        nVec++; if (exF !== expEx) begin nErr++; $display("FAIL jal_ex: got %h want %h", exF, expEx); end
        drive(6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        nVec++; if (memF !== MEM_JAL) begin nErr++; $display("FAIL jal_mem: got %h want %h", memF, MEM_JAL); end
        tick();
        nVec++; if (wbF !== WB_JAL) begin nErr++; $display("FAIL jal_wb: got %h want %h", wbF, WB_JAL); end
        nVec++; if (flushCntF !== 16'd1) begin nErr++; $display("FAIL jal_cnt: got %0d want 1", flushCntF); end
    endtask

    task automatic test_jump_stall();
        doReset();
        drive(OP_LW, 6'h00, 5'd1, 5'd8, 5'd0, 1'b0);
        tick();
        drive(OP_RTYPE, FN_JR, 5'd8, 5'd0, 5'd0, 1'b0);
        nVec++; if ({jumpF, flushF, stallF} !== 3'b101) begin nErr++; $display("FAIL js_stalled: got %b want 101", {jumpF, flushF, stallF}); end
        expQ.push_back(EX_NONE);
        tick();
        expEx = expQ.pop_front();
        nVec++; if (exF !== expEx) begin nErr++; $display("FAIL js_bubble: got %h want %h", exF, expEx); end
        nVec++; if ({jumpF, flushF, stallF} !== 3'b110) begin nErr++; $display("FAIL js_release: got %b want 110", {jumpF, flushF, stallF}); end
        expQ.push_back(EX_JR);
        tick();
        expEx = expQ.pop_front();
        nVec++; if (exF !== expEx) begin nErr++; $display("FAIL js_ex_jr: got %h want %h", exF, expEx); end
        nVec++; if (fwdAF !== 2'b01) begin nErr++; $display("FAIL js_fwd: got %b want 01", fwdAF); end
        nVec++; if ({stallCntF, flushCntF} !== {16'd1, 16'd1}) begin nErr++; $display("FAIL js_cnt: got %0d/%0d want 1/1", stallCntF, flushCntF); end
    endtask

    task automatic test_decode_misc();
        doReset();
        drive(OP_ANDI, 6'h00, 5'd1, 5'd5, 5'd0, 1'b0);
        expQ.push_back(EX_ANDI5);
        tick();
        expEx = expQ.pop_front();
        nVec++; if (exF !== expEx) begin nErr++; $display("FAIL dm_andi: got %h want %h", exF, expEx); end
        drive(OP_SW, 6'h00, 5'd1, 5'd5, 5'd7, 1'b0);
        nVec++; if (stallF !== 1'b0) begin nErr++; $display("FAIL dm_sw_stall: got %b want 0", stallF); end
        expQ.push_back(EX_SW);
        tick();
        expEx = expQ.pop_front();
        nVec++; if (exF !== expEx) begin nErr++; $display("FAIL dm_sw: got %h want %h", exF, expEx); end
        drive(OP_BEQ, 6'h00, 5'd1, 5'd2, 5'd3, 1'b0);
        expQ.push_back(EX_BEQ);
        tick();
        expEx = expQ.pop_front();
        nVec++; if (exF !== expEx) begin nErr++; $display("FAIL dm_beq: got %h want %h", exF, expEx); end
        nVec++; if (memF !== MEM_SW) begin nErr++; $display("FAIL dm_mem_sw: got %h want %h", memF, MEM_SW); end
        nVec++; if (wbF !== WB_ANDI5) begin nErr++; $display("FAIL dm_wb_andi: got %h want %h", wbF, WB_ANDI5); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        opcode = '0; funct = '0; rs = '0; rt = '0; rd = '0; brTaken = 1'b0;
        #12;
        test_reset();
        test_load_use();
        test_fwd_alu();
        test_nofwd();
        test_zero_reg();
        test_branch_flush();
        test_jal();
        test_jump_stall();
        test_decode_misc();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
